key_load_ctrl: RTL and testbench

Debounced push-button load controller that feeds the 4-bit operand/control registers in the board-level input path. It synchronizes one raw active-low push-button and a bank of slide switches into the 50 MHz domain and debounces the button. On each debounced press it emits a single-cycle active-low load strobe, plus a switch snapshot held stable for the downstream register's active-low enable and data inputs.

---
 rtl/key_load_ctrl.sv | 137 +++++++++++++
 tb/tb_key_load_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_load_ctrl.sv
// Debounced push-button load controller: synchronizes key_n/sw_i, debounces the key and
// emits a one-cycle active-low load strobe with a switch snapshot. Optional: AUTO_REPEAT_EN.
module key_load_ctrl #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input  logic             clk50M,
   input  logic             rst,
   input  logic             key_n,
   input  logic [WIDTH-1:0] sw_i,
   output logic             load_n,
   output logic [WIDTH-1:0] data_o,
   output logic             pressed
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("key_load_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_key_sync;
   logic [WIDTH-1:0] r_sw_meta;
   logic [WIDTH-1:0] r_sw_sync;
   logic             r_load_n;
   logic [WIDTH-1:0] r_data;
   logic             w_key;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] r_rpt;
`endif

   // Key flops reset to the released level so reset deassertion never looks like a press.
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         r_key_sync <= 2'b11;
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
      end else begin
         r_key_sync <= {r_key_sync[0], key_n};
         r_sw_meta  <= sw_i;
         r_sw_sync  <= r_sw_meta;
      end
   end

   assign w_key = r_key_sync[1];

   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_load_n <= 1'b1;
         r_data   <= '0;
`ifdef AUTO_REPEAT_EN
         r_rpt    <= '0;
`endif
      end else begin
         // NOTE: non-blocking default; a strobe assigned later in this block overrides it,
         // so load_n is high again on the edge after it was driven low.
         r_load_n <= 1'b1;
         case (r_state)
            IDLE: begin
               if (!w_key) begin
                  r_state <= PRESS_DB;
                  r_cnt   <= '0;
               end
            end
            PRESS_DB: begin
               if (w_key) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= HELD;
                  r_cnt    <= '0;
                  r_load_n <= 1'b0;
                  r_data   <= r_sw_sync;
`ifdef AUTO_REPEAT_EN
                  r_rpt    <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (w_key) begin
                  r_state <= RELEASE_DB;
                  r_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
               end else if (r_rpt == RPT_LAST) begin
                  r_load_n <= 1'b0;
                  r_data   <= r_sw_sync;
                  r_rpt    <= '0;
               end else begin
                  r_rpt <= r_rpt + RPT_W'(1);
`endif
               end
            end
            RELEASE_DB: begin
               if (!w_key) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                  r_rpt   <= '0;
`endif
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign load_n  = r_load_n;
   assign data_o  = r_data;
   assign pressed = (r_state == HELD) || (r_state == RELEASE_DB);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=6); a scoreboard
// queue holds the expected snapshot of every strobe. Follows AUTO_REPEAT_EN when defined.
module tb_key_load_ctrl;

   localparam int D = 4;
   localparam int R = 6;
`ifdef AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk50M = 1'b0;
   logic       rst;
   logic       key_n;
   logic [3:0] sw_i;
   logic       load_n;
   logic [3:0] data_o;
   logic       pressed;

   int         n_checks  = 0;
   int         n_errors  = 0;
   int         n_strobes = 0;
   logic [3:0] sb_q[$];

   always #10 clk50M = ~clk50M;

   key_load_ctrl #(
      .WIDTH          (4),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk50M (clk50M),
      .rst    (rst),
      .key_n  (key_n),
      .sw_i   (sw_i),
      .load_n (load_n),
      .data_o (data_o),
      .pressed(pressed)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk50M);
      #1;
   endtask

   // Every observed strobe must match the next expected snapshot.
   initial begin
      forever begin
         @(posedge clk50M);
         #1;
         if (rst === 1'b1 && load_n === 1'b0) begin
            n_strobes++;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("sb_data", 32'(data_o), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       exp_load;
      logic [3:0] exp_data;
      int         lat;

      rst   = 1'b0;
      key_n = 1'b0;
      sw_i  = 4'hF;

      // Reset held with key pressed and switches all ones.
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_load_n", 32'(load_n), 32'd1);
         check("rst_data", 32'(data_o), 32'd0);
         check("rst_pressed", 32'(pressed), 32'd0);
      end
      key_n = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      repeat (3) tick();

      // Clean press; switch change while held must not alter the snapshot.
      sw_i  = 4'hA;
      key_n = 1'b0;
      sb_q.push_back(4'hA);
      if (REP) begin
         sb_q.push_back(4'h3);
         sb_q.push_back(4'h3);
      end
      for (int e = 1; e <= 20; e++) begin
         tick();
         exp_load = !(e == 7 || (REP && (e == 13 || e == 19)));
         exp_data = (e < 7) ? 4'h0 : ((REP && e >= 13) ? 4'h3 : 4'hA);
         check("press_load_n", 32'(load_n), 32'(exp_load));
         check("press_data", 32'(data_o), 32'(exp_data));
         check("press_pressed", 32'(pressed), 32'(e >= 7));
         if (e == 10) sw_i = 4'h3;
      end

      // Release latency: IDLE D+3 edges after key_n is first sampled high.
      key_n = 1'b1;
      lat   = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (lat == 0 && pressed == 1'b0) lat = k;
      end
      check("rel_latency", 32'(lat), 32'(D + 3));
      check("rel_data_hold", 32'(data_o), REP ? 32'h3 : 32'hA);

      // Press bounce: 3 low / 1 high never completes the debounce.
      for (int b = 0; b < 5; b++) begin
         key_n = 1'b0;
         repeat (3) begin
            tick();
            check("pb_pressed", 32'(pressed), 32'd0);
            check("pb_load_n", 32'(load_n), 32'd1);
         end
         key_n = 1'b1;
         tick();
         check("pb_pressed_hi", 32'(pressed), 32'd0);
      end
      repeat (4) tick();
      sw_i  = 4'h5;
      key_n = 1'b0;
      sb_q.push_back(4'h5);
      for (int e = 1; e <= 9; e++) begin
         tick();
         check("pb_clean_load_n", 32'(load_n), 32'(e != 7));
         check("pb_clean_pressed", 32'(pressed), 32'(e >= 7));
      end
      key_n = 1'b1;
      repeat (10) tick();
      check("pb_released", 32'(pressed), 32'd0);
      check("pb_data", 32'(data_o), 32'h5);

      // Release bounce: 2-cycle high glitch while held.
      sw_i  = 4'h6;
      key_n = 1'b0;
      sb_q.push_back(4'h6);
      repeat (7) tick();
      check("rb_entry_load_n", 32'(load_n), 32'd0);
      check("rb_entry_pressed", 32'(pressed), 32'd1);
      key_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("rb_pressed", 32'(pressed), 32'd1);
         check("rb_load_n", 32'(load_n), 32'd1);
         if (k == 2) key_n = 1'b0;
      end
      key_n = 1'b1;
      repeat (12) tick();
      check("rb_released", 32'(pressed), 32'd0);

      // Reset during press debounce, released while key still low.
      key_n = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      check("rm_async_data", 32'(data_o), 32'd0);
      check("rm_async_pressed", 32'(pressed), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("rm_load_n", 32'(load_n), 32'd1);
         check("rm_pressed", 32'(pressed), 32'd0);
         check("rm_data", 32'(data_o), 32'd0);
         if (k == 3) key_n = 1'b1;
      end
      repeat (3) tick();

      // Long hold: entry strobe at edge 7, repeats every R edges when enabled.
      sw_i  = 4'h9;
      key_n = 1'b0;
      sb_q.push_back(4'h9);
      if (REP) begin
         sb_q.push_back(4'h1);
         sb_q.push_back(4'h2);
         sb_q.push_back(4'h3);
      end
      for (int e = 1; e <= 27; e++) begin
         tick();
         exp_load = !(e == 7 || (REP && (e == 7 + R || e == 7 + 2 * R || e == 7 + 3 * R)));
         if (e < 7)                    exp_data = 4'h0;
         else if (!REP || e < 7 + R)   exp_data = 4'h9;
         else if (e < 7 + 2 * R)       exp_data = 4'h1;
         else if (e < 7 + 3 * R)       exp_data = 4'h2;
         else                          exp_data = 4'h3;
         check("rpt_load_n", 32'(load_n), 32'(exp_load));
         check("rpt_data", 32'(data_o), 32'(exp_data));
         check("rpt_pressed", 32'(pressed), 32'(e >= 7));
         if (e == 8)  sw_i = 4'h1;
         if (e == 14) sw_i = 4'h2;
         if (e == 20) sw_i = 4'h3;
      end
      key_n = 1'b1;
      repeat (12) tick();
      check("rpt_released", 32'(pressed), 32'd0);

      repeat (3) tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("strobe_count", 32'(n_strobes), REP ? 32'd9 : 32'd4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
